// File: rtl/usb_rx_pkg.sv
// Shared types and sizing for the USB full-speed receive path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } rcv_timer_state_t;

    localparam int unsigned USB_CLKS_PER_BIT  = 8;
    localparam int unsigned USB_BITS_PER_BYTE = 8;
    localparam int unsigned USB_BIT_CNT_W     = 4;

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter with synchronous clear and load; rollover_flag pulses
// for one cycle after the counter wraps from rollover_val back to zero.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count,
    output logic                    rollover_flag
);

    // Priority: clear, then load, then count; load overrides both increment and wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else if (clear) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else if (load) begin
            count         <= load_val;
            rollover_flag <= 1'b0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count         <= '0;
                rollover_flag <= 1'b1;
            end else begin
                count         <= count + NUM_CNT_BITS'(1);
                rollover_flag <= 1'b0;
            end
        end else begin
            rollover_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/rcv_timer.sv
// USB full-speed receive bit timer: re-phases on d_edge, strobes mid-bit,
// and pulses byte_received after every BITS_PER_BYTE non-stuffed bits.
module rcv_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE  = 3,
    parameter int unsigned EDGE_PHASE    = 2,
    parameter int unsigned BITS_PER_BYTE = USB_BITS_PER_BYTE
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     d_edge,
    input  logic                     rcving,
    input  logic                     stuff_bit,
    output logic                     shift_enable,
    output logic                     byte_received,
    output logic [USB_BIT_CNT_W-1:0] bit_cnt
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    rcv_timer_state_t state;
    logic [CNT_W-1:0] clk_cnt;
    logic             clk_wrap_unused;
    logic             abort;
    logic             phase_load;
    logic             phase_run;
    logic             bit_count_en;

    assign abort        = !rcving;
    assign phase_load   = d_edge && (state != IDLE);
    assign phase_run    = (state == RUN);
    assign shift_enable = phase_run && (clk_cnt == CNT_W'(SAMPLE_PHASE));
    assign bit_count_en = shift_enable && !stuff_bit;

    // Receive-mode FSM; dropping rcving returns to IDLE from any state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= SYNC;
                SYNC:    if (d_edge) state <= RUN;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // Per-bit phase counter; every edge reloads EDGE_PHASE to absorb detector latency.
    flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (abort),
        .count_enable (phase_run),
        .load         (phase_load),
        .load_val     (CNT_W'(EDGE_PHASE)),
        .rollover_val (CNT_W'(CLKS_PER_BIT - 1)),
        .count        (clk_cnt),
        .rollover_flag(clk_wrap_unused)
    );

    // Counted bits within the current byte; its wrap flag is the byte pulse.
    flex_counter #(
        .NUM_CNT_BITS(USB_BIT_CNT_W)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (abort),
        .count_enable (bit_count_en),
        .load         (1'b0),
        .load_val     ('0),
        .rollover_val (USB_BIT_CNT_W'(BITS_PER_BYTE - 1)),
        .count        (bit_cnt),
        .rollover_flag(byte_received)
    );

endmodule

// File: tb/tb_rcv_timer.sv
// Bench for rcv_timer: per-cycle vector table, then scoreboarded bit sequences.
module tb_rcv_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       rcving;
    logic       stuff_bit;
    logic       shift_enable;
    logic       byte_received;
    logic [3:0] bit_cnt;

    always #5 clk = ~clk;

    rcv_timer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .rcving       (rcving),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_cnt      (bit_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       r;
        logic       e;
        logic       s;
        logic       sh;
        logic       by;
        logic [3:0] bc;
    } vec_t;

    typedef struct {
        int         at;
        logic [3:0] bits;
    } strobe_exp_t;

    vec_t        tbl[20];
    strobe_exp_t exp_strobe[$];
    int          exp_byte[$];
    strobe_exp_t mon_e;
    int          mon_b;
    bit          mon_en = 1'b0;

    int obs_strobes;
    int obs_bytes;
    int obs_byte_cyc;
    int obs_strobe_cyc[$];

    // Behavioural model: state during the current cycle, last edge, counted bits.
    int         m_state = 0;
    int         m_last  = 0;
    logic [3:0] m_bits  = 4'd0;
    bit         m_strobe;
    int         seq_strobes;
    int         stuff_at;
    int         edge0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (shift_enable === 1'b1) begin
                obs_strobes++;
                obs_strobe_cyc.push_back(cyc);
                if (exp_strobe.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_strobe.pop_front();
                    check("strobe_cycle", cyc, mon_e.at);
                    check("strobe_bit_cnt", 32'(bit_cnt), 32'(mon_e.bits));
                end
            end
            if (byte_received === 1'b1) begin
                obs_bytes++;
                obs_byte_cyc = cyc;
                if (exp_byte.size() == 0) begin
                    check("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    mon_b = exp_byte.pop_front();
                    check("byte_cycle", cyc, mon_b);
                end
            end
        end
    end

    // One clock of stimulus; expectations for this cycle are pushed before the monitor samples.
    task automatic step(input logic r, input logic e);
        @(posedge clk);
        #1;
        m_strobe = (m_state == 2) && (((cyc - m_last) % 8) == 2);
        rcving   = r;
        d_edge   = e;
        if (m_strobe) begin
            strobe_exp_t x;
            x.at      = cyc;
            x.bits    = m_bits;
            stuff_bit = (seq_strobes == stuff_at);
            seq_strobes++;
            exp_strobe.push_back(x);
            if (!stuff_bit) begin
                if (m_bits == 4'd7) begin
                    m_bits = 4'd0;
                    if (r) exp_byte.push_back(cyc + 1);
                end else begin
                    m_bits = m_bits + 4'd1;
                end
            end
        end else begin
            stuff_bit = 1'($urandom_range(0, 1));
        end
        if (!r) begin
            m_state = 0;
            m_bits  = 4'd0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (e) begin m_state = 2; m_last = cyc; end
                default: if (e) m_last = cyc;
            endcase
        end
    endtask

    task automatic run_bits(input int n, input int gap_a, input int gap_b);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (i % 2 == 1) ? gap_b : gap_a;
            step(1'b1, 1'b1);
            if (i == 0) edge0 = cyc;
            for (int j = 1; j < gap; j++) step(1'b1, 1'b0);
        end
    endtask

    task automatic start_seq(input int stuff_idx);
        stuff_at    = stuff_idx;
        seq_strobes = 0;
        step(1'b0, 1'b0);
        @(negedge clk);
        obs_strobes  = 0;
        obs_bytes    = 0;
        obs_byte_cyc = -1;
        obs_strobe_cyc.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic end_seq(input string name);
        step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        check({name, "_strobes_drained"}, 32'(exp_strobe.size()), 32'd0);
        check({name, "_bytes_drained"}, 32'(exp_byte.size()), 32'd0);
    endtask

    initial begin
        // rcving, d_edge, stuff_bit | shift_enable, byte_received, bit_cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        n_rst     = 1'b0;
        d_edge    = 1'b0;
        rcving    = 1'b0;
        stuff_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {29'd0, shift_enable, byte_received, 1'b0} | 32'(bit_cnt), 32'd0);
        n_rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            rcving    = tbl[i].r;
            d_edge    = tbl[i].e;
            stuff_bit = tbl[i].s;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'({shift_enable, byte_received, bit_cnt}),
                  32'({tbl[i].sh, tbl[i].by, tbl[i].bc}));
        end

        mon_en = 1'b1;

        // Nominal: strobe 2 cycles after the first edge, then every 8; byte after the 8th.
        start_seq(-1);
        run_bits(9, 8, 8);
        end_seq("nominal");
        check("nominal_strobes", obs_strobes, 32'd9);
        check("nominal_bytes", obs_bytes, 32'd1);
        check("nominal_first", obs_strobe_cyc[0], edge0 + 2);
        for (int i = 1; i < obs_strobe_cyc.size(); i++)
            check($sformatf("nominal_spacing%0d", i), obs_strobe_cyc[i] - obs_strobe_cyc[i-1], 32'd8);
        if (obs_strobe_cyc.size() >= 8)
            check("nominal_byte_latency", obs_byte_cyc, obs_strobe_cyc[7] + 1);

        // Drift: alternate 7/9 clock edge spacing.
        start_seq(-1);
        run_bits(10, 7, 9);
        end_seq("drift");
        check("drift_strobes", obs_strobes, 32'd10);
        check("drift_bytes", obs_bytes, 32'd1);

        // Stuffed third bit: byte only after the ninth strobe.
        start_seq(2);
        run_bits(9, 8, 8);
        end_seq("stuff");
        check("stuff_strobes", obs_strobes, 32'd9);
        check("stuff_bytes", obs_bytes, 32'd1);
        if (obs_strobe_cyc.size() >= 9)
            check("stuff_byte_latency", obs_byte_cyc, obs_strobe_cyc[8] + 1);

        // Collision: every edge lands on the previous bit's strobe.
        start_seq(-1);
        run_bits(10, 2, 2);
        end_seq("collision");
        check("collision_strobes", obs_strobes, 32'd10);
        check("collision_bytes", obs_bytes, 32'd1);

        // Long run without edges: free-runs at 8 clocks per bit.
        start_seq(-1);
        run_bits(1, 20, 20);
        end_seq("freerun");
        check("freerun_strobes", obs_strobes, 32'd3);

        // Abort at bit_cnt=4, then re-entry must wait in SYNC for an edge.
        start_seq(-1);
        run_bits(4, 8, 8);
        check("abort_pre_bit_cnt", 32'(bit_cnt), 32'd4);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        #1;
        check("abort_bit_cnt", 32'(bit_cnt), 32'd0);
        check("abort_byte", 32'(byte_received), 32'd0);
        repeat (15) step(1'b1, 1'b0);
        check("abort_sync_wait", obs_strobes, 32'd4);
        run_bits(2, 8, 8);
        end_seq("abort");
        check("abort_resume_strobes", obs_strobes, 32'd6);
        check("abort_no_byte", obs_bytes, 32'd0);

        // Async reset in the middle of a strobe with bit_cnt=5.
        start_seq(-1);
        run_bits(5, 8, 8);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #1;
        check("prereset_strobe", 32'(shift_enable), 32'd1);
        check("prereset_bit_cnt", 32'(bit_cnt), 32'd5);
        mon_en = 1'b0;
        n_rst  = 1'b0;
        #1;
        check("reset_async", 32'({shift_enable, byte_received, bit_cnt}), 32'd0);
        exp_strobe.delete();
        exp_byte.delete();
        m_state = 0;
        m_bits  = 4'd0;
        @(posedge clk);
        #1;
        n_rst  = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        obs_strobes = 0;
        repeat (12) step(1'b1, 1'b0);
        check("reset_idle_sync", obs_strobes, 32'd0);
        end_seq("reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
